// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between IFU fetches and LSU loads/stores.
// Optional wait-state watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant_lsu,
    output logic              arb_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_IFU,
        S_REQ_LSU,
        S_WAIT_IFU,
        S_WAIT_LSU
    } state_t;

    state_t            state_q, state_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wen_q, mem_wen_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]        mem_wmask_q, mem_wmask_d;
    logic              grant_lsu_q, grant_lsu_d;
    logic              arb_timeout_q, arb_timeout_d;

    logic is_idle;
    logic in_wait;
    logic pick_lsu;
    logic tmo_hit;

    assign is_idle = (state_q == S_IDLE);
    assign in_wait = (state_q == S_WAIT_IFU) || (state_q == S_WAIT_LSU);

    // grant_lsu_q doubles as last_grant: on a tie the other side wins
    assign pick_lsu = lsu_req_valid && (!ifu_req_valid || !grant_lsu_q);

    assign ifu_req_ready = is_idle && ifu_req_valid && !pick_lsu;
    assign lsu_req_ready = is_idle && pick_lsu;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // a real response in the limit cycle takes priority over the timeout
    assign tmo_hit = in_wait && !mem_resp_valid
                   && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // wait-cycle counter, held at zero outside WAIT so entry starts fresh
    always_comb begin
        cnt_d = '0;
        if (in_wait) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // watchdog counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int tmo_unused = TIMEOUT_CYCLES;

    assign tmo_hit = 1'b0;
`endif

    // response routing: only the owner in WAIT sees the memory data
    always_comb begin
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        lsu_rdata      = '0;
        if (state_q == S_WAIT_IFU) begin
            ifu_resp_valid = mem_resp_valid || tmo_hit;
            ifu_rdata      = tmo_hit ? '0 : mem_rdata;
        end
        if (state_q == S_WAIT_LSU) begin
            lsu_resp_valid = mem_resp_valid || tmo_hit;
            lsu_rdata      = tmo_hit ? '0 : mem_rdata;
        end
    end

    // next-state and request-capture logic
    always_comb begin
        state_d         = state_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_addr_d      = mem_addr_q;
        mem_wen_d       = mem_wen_q;
        mem_wdata_d     = mem_wdata_q;
        mem_wmask_d     = mem_wmask_q;
        grant_lsu_d     = grant_lsu_q;
        arb_timeout_d   = arb_timeout_q | tmo_hit;
        unique case (state_q)
            S_IDLE: begin
                if (ifu_req_ready) begin
                    state_d         = S_REQ_IFU;
                    mem_req_valid_d = 1'b1;
                    mem_addr_d      = ifu_addr;
                    mem_wen_d       = 1'b0;
                    mem_wdata_d     = '0;
                    mem_wmask_d     = '0;
                    grant_lsu_d     = 1'b0;
                end else if (lsu_req_ready) begin
                    state_d         = S_REQ_LSU;
                    mem_req_valid_d = 1'b1;
                    mem_addr_d      = lsu_addr;
                    mem_wen_d       = lsu_wen;
                    mem_wdata_d     = lsu_wdata;
                    mem_wmask_d     = lsu_wen ? lsu_wmask : 8'h00;
                    grant_lsu_d     = 1'b1;
                end
            end
            S_REQ_IFU, S_REQ_LSU: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d = (state_q == S_REQ_IFU) ? S_WAIT_IFU
                                                     : S_WAIT_LSU;
                end
            end
            S_WAIT_IFU, S_WAIT_LSU: begin
                if (mem_resp_valid || tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d         = S_IDLE;
                mem_req_valid_d = 1'b0;
            end
        endcase
    end

    // state and registered bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_wen_q       <= 1'b0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
            grant_lsu_q     <= 1'b0;
            arb_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            mem_wen_q       <= mem_wen_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wmask_q     <= mem_wmask_d;
            grant_lsu_q     <= grant_lsu_d;
            arb_timeout_q   <= arb_timeout_d;
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wen       = mem_wen_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;
    assign grant_lsu     = grant_lsu_q;
    assign arb_timeout   = arb_timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed IFU/LSU traffic,
// expected responses queued at issue and checked by a separate monitor.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ifu_req_valid = 1'b0;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_addr = '0;
    logic          ifu_resp_valid;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid = 1'b0;
    logic          lsu_req_ready;
    logic [AW-1:0] lsu_addr = '0;
    logic          lsu_wen = 1'b0;
    logic [DW-1:0] lsu_wdata = '0;
    logic [7:0]    lsu_wmask = '0;
    logic          lsu_resp_valid;
    logic [DW-1:0] lsu_rdata;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [7:0]    mem_wmask;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          grant_lsu;
    logic          arb_timeout;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid),
        .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid),
        .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid),
        .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr),
        .mem_wen(mem_wen),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata),
        .grant_lsu(grant_lsu),
        .arb_timeout(arb_timeout)
    );

    typedef struct {
        bit            is_lsu;
        logic [DW-1:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input bit is_lsu, input logic [DW-1:0] rd);
        exp_t e;
        e.is_lsu = is_lsu;
        e.rd     = rd;
        exp_q.push_back(e);
    endtask

    // memory side: accept after rdy_dly cycles, respond rsp_dly later
    task automatic serve(input logic [DW-1:0] rd, input int rdy_dly,
                         input int rsp_dly);
        int n = 0;
        while (!mem_req_valid && n < 50) begin
            tick();
            n++;
        end
        if (!mem_req_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL serve_wait: mem_req_valid never rose");
            return;
        end
        repeat (rdy_dly) tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        repeat (rsp_dly) tick();
        mem_resp_valid = 1'b1;
        mem_rdata      = rd;
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // monitor: every response pulse must match the head of the queue
    always @(negedge clk) begin
        exp_t e;
        if (ifu_resp_valid || lsu_resp_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_resp: ifu=%0b lsu=%0b none expected",
                         ifu_resp_valid, lsu_resp_valid);
            end else begin
                e = exp_q.pop_front();
                chk("resp_port", 64'({ifu_resp_valid, lsu_resp_valid}),
                    e.is_lsu ? 64'h1 : 64'h2);
                chk("resp_rdata", 64'(e.is_lsu ? lsu_rdata : ifu_rdata),
                    64'(e.rd));
                chk("resp_other_rdata",
                    64'(e.is_lsu ? ifu_rdata : lsu_rdata), 64'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'h0);
        chk("rst_mem_addr", 64'(mem_addr), 64'h0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'h0);
        chk("rst_ctl", 64'({mem_wen, mem_wmask, grant_lsu, arb_timeout}),
            64'h0);
        chk("rst_comb", 64'({ifu_req_ready, lsu_req_ready, ifu_resp_valid,
                             lsu_resp_valid, ifu_rdata, lsu_rdata}), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // IFU alone, minimum turnaround
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        mem_req_ready = 1'b1;
        @(negedge clk);
        chk("f_ifu_ready_T", 64'({ifu_req_ready, lsu_req_ready}), 64'h2);
        tick();
        ifu_req_valid = 1'b0;
        ifu_addr      = '0;
        @(negedge clk);
        chk("f_req_valid_T1", 64'(mem_req_valid), 64'h1);
        chk("f_addr_T1", 64'(mem_addr), 64'h8000_0000);
        chk("f_ctl_T1", 64'({mem_wen, mem_wmask, grant_lsu}), 64'h0);
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h0000_0513;
        expect_resp(1'b0, 32'h0000_0513);
        @(negedge clk);
        chk("f_resp_T2", 64'(ifu_resp_valid), 64'h1);
        chk("f_req_drop_T2", 64'(mem_req_valid), 64'h0);
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        ifu_req_valid  = 1'b1;
        ifu_addr       = 32'h8000_0004;
        @(negedge clk);
        chk("f_accept_T3", 64'(ifu_req_ready), 64'h1);
        tick();
        ifu_req_valid = 1'b0;
        expect_resp(1'b0, 32'h0011_0113);
        serve(32'h0011_0113, 0, 0);

        // round-robin ties after a fresh reset
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0010;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0200;
        lsu_wen       = 1'b0;
        @(negedge clk);
        chk("rr1_lsu_first", 64'({ifu_req_ready, lsu_req_ready}), 64'h1);
        tick();
        expect_resp(1'b1, 32'hA5A5_0001);
        @(negedge clk);
        chk("rr1_grant", 64'({grant_lsu, mem_addr}), {32'h1, 32'h8000_0200});
        chk("rr1_busy_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'h0);
        serve(32'hA5A5_0001, 0, 0);
        @(negedge clk);
        chk("rr2_ifu_next", 64'({ifu_req_ready, lsu_req_ready}), 64'h2);
        tick();
        ifu_req_valid = 1'b0;
        expect_resp(1'b0, 32'h0000_0093);
        @(negedge clk);
        chk("rr2_grant", 64'({grant_lsu, mem_addr}), {32'h0, 32'h8000_0010});
        serve(32'h0000_0093, 1, 2);
        ifu_req_valid = 1'b1;
        @(negedge clk);
        chk("rr3_lsu_again", 64'({ifu_req_ready, lsu_req_ready}), 64'h1);
        tick();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        expect_resp(1'b1, 32'hA5A5_0002);
        serve(32'hA5A5_0002, 0, 1);

        // store with memory stalling the request
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0100;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 8'h0F;
        @(negedge clk);
        chk("st_ready", 64'(lsu_req_ready), 64'h1);
        tick();
        lsu_req_valid = 1'b0;
        lsu_addr      = '0;
        lsu_wen       = 1'b0;
        lsu_wdata     = '0;
        lsu_wmask     = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("st_hold_valid", 64'(mem_req_valid), 64'h1);
            chk("st_hold_addr", 64'(mem_addr), 64'h8000_0100);
            chk("st_hold_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
            chk("st_hold_ctl", 64'({mem_wen, mem_wmask}), 64'h10F);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        @(negedge clk);
        chk("st_single_hs", 64'(mem_req_valid), 64'h0);
        chk("st_no_early_ack", 64'(lsu_resp_valid), 64'h0);
        tick();
        mem_resp_valid = 1'b1;
        expect_resp(1'b1, 32'h0);
        @(negedge clk);
        chk("st_ack", 64'(lsu_resp_valid), 64'h1);
        tick();
        mem_resp_valid = 1'b0;

        // reset while waiting on an LSU load
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_0300;
        mem_req_ready = 1'b1;
        tick();
        lsu_req_valid = 1'b0;
        tick();
        mem_req_ready = 1'b0;
        @(negedge clk);
        chk("rw_waiting", 64'({mem_req_valid, lsu_resp_valid, grant_lsu}),
            64'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rw_regs_zero", 64'({mem_req_valid, mem_wen, mem_wmask,
                                 grant_lsu, arb_timeout}), 64'h0);
        chk("rw_addr_zero", 64'(mem_addr), 64'h0);
        chk("rw_comb_zero", 64'({ifu_req_ready, lsu_req_ready,
                                 ifu_resp_valid, lsu_resp_valid}), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1234_5678;
        @(negedge clk);
        chk("rw_late_resp", 64'({ifu_resp_valid, lsu_resp_valid, lsu_rdata}),
            64'h0);
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;

        // stray responses in IDLE and in REQ
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'hFFFF_0000;
        @(negedge clk);
        chk("stray_idle", 64'({ifu_resp_valid, lsu_resp_valid}), 64'h0);
        tick();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0020;
        @(negedge clk);
        chk("stray_still_idle", 64'(ifu_req_ready), 64'h1);
        tick();
        ifu_req_valid = 1'b0;
        @(negedge clk);
        chk("stray_req", 64'({mem_req_valid, ifu_resp_valid}), 64'h2);
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        expect_resp(1'b0, 32'h0000_0297);
        serve(32'h0000_0297, 0, 0);

`ifdef ARB_TIMEOUT_EN
        // watchdog fires after TMO silent wait cycles
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0040;
        mem_req_ready = 1'b1;
        tick();
        ifu_req_valid = 1'b0;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            chk("tmo_quiet", 64'({ifu_resp_valid, arb_timeout}), 64'h0);
            tick();
        end
        expect_resp(1'b0, 32'h0);
        @(negedge clk);
        chk("tmo_pulse", 64'(ifu_resp_valid), 64'h1);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("tmo_sticky", 64'(arb_timeout), 64'h1);
            tick();
        end
`else
        @(negedge clk);
        chk("tmo_absent", 64'(arb_timeout), 64'h0);
`endif

        repeat (2) tick();
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
